demux_stream_n: RTL and testbench

//  Parametrised 1-to-N packet demultiplexer with valid/ready handshakes.

---
 rtl/demux_stream_n.sv | 134 +++++++++++++
 tb/tb_demux_stream_n.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n.sv
// 1-to-N packet demultiplexer: the first beat's sel picks the destination, and each output
// has its own one-entry register stage. Optional beat/drop counters: define DEMUX_BEATCNT_EN.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] y_data,
  output logic [N_OUT-1:0]        y_valid,
  output logic [N_OUT-1:0]        y_last,
  input  logic [N_OUT-1:0]        y_ready,
  output logic                    busy
`ifdef DEMUX_BEATCNT_EN
  ,
  output logic [N_OUT*16-1:0]     y_beats,
  output logic [15:0]             drop_cnt
`endif
);

  // Handshake: a beat moves on any edge where valid & ready are both high. in_ready never
  // looks at in_valid, and y_valid/y_data/y_last stay frozen until y_ready takes the beat.
  localparam int NP = 1 << SEL_W;
  localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PKT  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [SEL_W-1:0]        ch_q, ch_d;
  logic [N_OUT-1:0]        y_valid_q, y_valid_d;
  logic [N_OUT-1:0]        y_last_q, y_last_d;
  logic [N_OUT*DATA_W-1:0] y_data_q, y_data_d;
  logic [SEL_W-1:0]        cur_sel;
  logic                    route_en;
  logic                    accept;
  logic [NP-1:0]           vld_pad, rdy_pad;
  logic [N_OUT-1:0]        load;

  assign cur_sel = (state_q == IDLE) ? sel : ch_q;
  assign vld_pad = NP'(y_valid_q);
  assign rdy_pad = NP'(y_ready);

  // route_en is low whenever the beat will be discarded.
  always_comb begin
    route_en = 1'b0;
    if (state_q == PKT)       route_en = 1'b1;
    else if (state_q == IDLE) route_en = ({1'b0, sel} < N_OUT_L);
  end

  assign in_ready = route_en ? (~vld_pad[cur_sel] | rdy_pad[cur_sel]) : 1'b1;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++)
      load[k] = accept & route_en & (cur_sel == SEL_W'(k));
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    y_data_d  = y_data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (load[k]) begin
        y_valid_d[k]                  = 1'b1;
        y_data_d[k*DATA_W +: DATA_W]  = in_data;
        y_last_d[k]                   = in_last;
      end else if (y_ready[k]) begin
        y_valid_d[k] = 1'b0;
      end
    end
    case (state_q)
      IDLE: if (accept) begin
        ch_d = sel;
        if (!in_last) state_d = route_en ? PKT : DROP;
      end
      PKT, DROP: if (accept && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      y_valid_q <= '0;
      y_last_q  <= '0;
      y_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      y_data_q  <= y_data_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign y_data  = y_data_q;
  assign busy    = (state_q != IDLE);

`ifdef DEMUX_BEATCNT_EN
  logic [N_OUT*16-1:0] beats_q;
  logic [15:0]         drop_q;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q <= '0;
      drop_q  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (y_valid_q[k] && y_ready[k]) beats_q[k*16 +: 16] <= beats_q[k*16 +: 16] + 16'd1;
      if (accept && !route_en) drop_q <= drop_q + 16'd1;
    end
  end

  assign y_beats  = beats_q;
  assign drop_cnt = drop_q;
`else
  // Default build: no counter logic.
`endif

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n (N_OUT=3 so out-of-range selects are exercised); a per-channel
// expected-beat queue plus a packet-level destination tracker forms the reference.
module tb_demux_stream_n;
  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [1:0]   sel = '0;
  logic [N*W-1:0] y_data;
  logic [N-1:0] y_valid, y_last;
  logic [N-1:0] y_ready = '0;
  logic         busy;
`ifdef DEMUX_BEATCNT_EN
  logic [N*16-1:0] y_beats;
  logic [15:0]     drop_cnt;
`endif

  demux_stream_n #(.DATA_W(W), .N_OUT(N), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .sel(sel), .y_data(y_data),
    .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready), .busy(busy)
`ifdef DEMUX_BEATCNT_EN
    , .y_beats(y_beats), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queued beats per channel, last beat loaded per channel, packet tracking.
  logic [W:0] exp_q [N][$];
  logic [W:0] hold [N];
  logic       in_pkt = 1'b0;
  int         dest = 0;
  int         drops = 0;
  int         beats [N];
  logic       last_acc = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    int d;
    logic exp_rdy, acc;
    #1;
    d = in_pkt ? dest : int'(sel);
    exp_rdy = (d >= N) ? 1'b1 : ((exp_q[d].size() == 0) || y_ready[d]);
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(in_pkt));
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("y_valid%0d", k), 32'(y_valid[k]), 32'(exp_q[k].size() != 0));
      chk($sformatf("y_beat%0d", k), 32'({y_last[k], y_data[k*W +: W]}),
          32'((exp_q[k].size() != 0) ? exp_q[k][0] : hold[k]));
`ifdef DEMUX_BEATCNT_EN
      chk($sformatf("y_beats%0d", k), 32'(y_beats[k*16 +: 16]), 32'(beats[k] % 65536));
`endif
    end
`ifdef DEMUX_BEATCNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(drops % 65536));
`endif
    acc = rst_n && in_valid && exp_rdy;
    last_acc = acc;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        exp_q[k].delete();
        hold[k] = '0;
        beats[k] = 0;
      end
      in_pkt = 1'b0;
      drops = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (exp_q[k].size() != 0 && y_ready[k]) begin
          void'(exp_q[k].pop_front());
          beats[k]++;
        end
      if (acc) begin
        if (d < N) begin
          exp_q[d].push_back({in_last, in_data});
          hold[d] = {in_last, in_data};
        end else begin
          drops++;
        end
        if (!in_pkt && !in_last) begin
          in_pkt = 1'b1;
          dest = d;
        end else if (in_pkt && in_last) begin
          in_pkt = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] dat, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; sel = s; in_data = dat; in_last = l;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    chk("send_accepted", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      hold[k] = '0;
      beats[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-packet, then the next beat starts a fresh packet.
    y_ready = '1;
    send(2'd0, 8'h11, 1'b0);
    send(2'd0, 8'h12, 1'b0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(2'd1, 8'h21, 1'b1);
    tick();

    // Four-beat packet to channel 2 at full rate.
    for (int i = 0; i < 4; i++) send(2'd2, 8'hA0 + 8'(i), (i == 3));
    tick(); tick();

    // sel wanders after the first beat; the packet stays on channel 2.
    send(2'd2, 8'hB0, 1'b0);
    for (int i = 1; i < 4; i++) send(2'd1, 8'hB0 + 8'(i), (i == 3));
    tick();

    // Channel 0 stalls while channel 1 drains its earlier beat.
    y_ready = '0;
    send(2'd1, 8'h55, 1'b1);
    y_ready = 3'b010;
    send(2'd0, 8'h10, 1'b0);
    in_valid = 1'b1; sel = 2'd2; in_data = 8'h11; in_last = 1'b0;
    repeat (5) tick();
    y_ready = '1;
    send(2'd0, 8'h11, 1'b0);
    send(2'd0, 8'h12, 1'b1);
    tick();

    // Out-of-range select: three beats discarded.
    for (int i = 0; i < 3; i++) send(2'd3, 8'hD0 + 8'(i), (i == 2));
    tick();

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      in_data  = 8'($urandom_range(0, 255));
      in_last  = ($urandom_range(0, 3) == 0);
      y_ready  = 3'($urandom_range(0, 7));
      rst_n    = !(i == 300 || i == 301);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    y_ready = '1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
